// File: rtl/if_id_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_id_stage_pkg
// Shared pipeline definitions for the IF/ID stage: the canonical NOP word,
// the IF/ID control state encoding, the opcodes the front end cares about,
// and a saturating increment used by the performance counters.
// ---------------------------------------------------------------------------
package if_id_stage_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } pipe_state_e;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Combinational load-use comparator. Flags a hazard when the instruction in
// ID reads a register that a load currently in EX is about to write.
//   rs1, rs2       : source registers of the instruction in IF/ID
//   id_ex_rd       : destination register held in ID/EX
//   id_ex_memread  : ID/EX holds a load
//   valid          : IF/ID holds a real instruction
//   hazard         : stall required this cycle
// ---------------------------------------------------------------------------
module hazard_detect (
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] id_ex_rd,
    input  logic       id_ex_memread,
    input  logic       valid,
    output logic       hazard
);

    // x0 is never written, so a load targeting it cannot create a dependency.
    assign hazard = valid && id_ex_memread && (id_ex_rd != 5'd0) &&
                    ((id_ex_rd == rs1) || (id_ex_rd == rs2));

endmodule

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
// IF/ID pipeline register with load-use stall and branch flush control.
//   clk, reset         : clock, synchronous active-high reset
//   pc_in, instr_in    : fetched PC and instruction
//   id_ex_memread/rd   : load status of the instruction in ID/EX
//   branch_taken       : branch resolved taken this cycle
//   pc_out, instr_out  : registered IF/ID contents, valid_out qualifies them
//   rs1/rs2/rd/opcode/func : fields decoded from instr_out
//   pc_write           : PC register enable (combinational)
//   bubble             : zero the control going into ID/EX (combinational)
//   stall_cnt/flush_cnt: saturating performance counters
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal fetch; IF/ID loads every cycle
// STALL | previous cycle held IF/ID for a load-use hazard (one cycle)
// FLUSH | previous cycle squashed IF/ID to NOP for a taken branch
// ---------------------------------------------------------------------------
module if_id_stage
    import if_id_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        id_ex_memread,
    input  logic [4:0]  id_ex_rd,
    input  logic        branch_taken,
    output logic [63:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [6:0]  opcode,
    output logic [3:0]  func,
    output logic        pc_write,
    output logic        bubble,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    pipe_state_e state;
    logic        hazard;

    assign rs1    = instr_out[19:15];
    assign rs2    = instr_out[24:20];
    assign rd     = instr_out[11:7];
    assign opcode = instr_out[6:0];
    assign func   = {instr_out[30], instr_out[14:12]};

    hazard_detect u_hazard_detect (
        .rs1           (rs1),
        .rs2           (rs2),
        .id_ex_rd      (id_ex_rd),
        .id_ex_memread (id_ex_memread),
        .valid         (valid_out),
        .hazard        (hazard)
    );

    // A taken branch wins over a stall: the stalled instruction is on the
    // wrong path anyway, so the PC must move to the branch target.
    assign pc_write = reset || branch_taken || !hazard;
    assign bubble   = reset || branch_taken || hazard;

    // STALL and FLUSH differ from RUN only in history; every state reacts to
    // branch_taken and hazard the same way, so one cycle in either returns
    // to RUN unless a new event arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out    <= 64'd0;
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
            state     <= RUN;
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else if (branch_taken) begin
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
            state     <= FLUSH;
            flush_cnt <= sat_inc(flush_cnt);
        end else if (hazard) begin
            state     <= STALL;
            stall_cnt <= sat_inc(stall_cnt);
        end else begin
            pc_out    <= pc_in;
            instr_out <= instr_in;
            valid_out <= 1'b1;
            state     <= RUN;
        end
    end

endmodule
